// File: rtl/floo_htif_mailbox.sv
// floo_htif_mailbox: device-side tohost/fromhost mailbox for the FlooNoC test
// harness. This is a single-outstanding memory-mapped responder. Nonzero,
// non-exit tohost words are forwarded to the host. The block also latches the
// program exit code and holds one fromhost word offered by the host.
module floo_htif_mailbox #(
  parameter int unsigned          AddrWidth = 32,
  parameter logic [AddrWidth-1:0] BaseAddr  = 32'h0000_1000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // device request
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_write_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [63:0]          req_wdata_i,
  input  logic [7:0]           req_strb_i,
  // device response
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [63:0]          rsp_rdata_o,
  output logic                 rsp_err_o,
  // host side
  output logic                 tohost_valid_o,
  output logic [63:0]          tohost_data_o,
  input  logic                 tohost_ready_i,
  input  logic                 fromhost_valid_i,
  input  logic [63:0]          fromhost_data_i,
  output logic                 fromhost_ready_o,
  // exit latch
  output logic                 exit_valid_o,
  output logic [31:0]          exit_code_o
);

  typedef enum logic {IDLE, RESP} state_e;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } rsp_t;

  localparam logic [AddrWidth-1:0] ToAddr   = BaseAddr;
  localparam logic [AddrWidth-1:0] FromAddr = BaseAddr + AddrWidth'(8);

  state_e      state_q;
  logic [63:0] tohost_q, fromhost_q;
  logic        tohost_pend_q;

  logic        aligned, hit_to, hit_from, stall;
  logic        req_fire, wr_to, wr_from, pop, host_load;
  logic [63:0] to_merged, from_merged;
  rsp_t        rsp_d;

  // Byte-lane merge of write data into an existing register value.
  function automatic logic [63:0] merge(input logic [63:0] cur,
                                        input logic [63:0] wdata,
                                        input logic [7:0]  strb);
    logic [63:0] m;
    m = cur;
    for (int b = 0; b < 8; b++)
      if (strb[b]) m[b*8 +: 8] = wdata[b*8 +: 8];
    return m;
  endfunction

  assign aligned  = (req_addr_i[2:0] == 3'b000);
  assign hit_to   = aligned && (req_addr_i == ToAddr);
  assign hit_from = aligned && (req_addr_i == FromAddr);

  // A pending tohost word blocks further tohost writes. The stall uses the
  // registered pend bit, so a same-cycle pop does not release the write early.
  assign stall       = req_write_i && hit_to && tohost_pend_q;
  assign req_ready_o = (state_q == IDLE) && !stall;
  assign req_fire    = req_valid_i && req_ready_o;
  assign wr_to       = req_fire && req_write_i && hit_to;
  assign wr_from     = req_fire && req_write_i && hit_from;

  assign to_merged   = merge(tohost_q,   req_wdata_i, req_strb_i);
  assign from_merged = merge(fromhost_q, req_wdata_i, req_strb_i);

  assign tohost_valid_o = tohost_pend_q;
  assign tohost_data_o  = tohost_q;
  assign pop            = tohost_pend_q && tohost_ready_i;

  // The device write wins over a host offer in the same cycle. The offer
  // stays pending because ready is withheld.
  assign fromhost_ready_o = (fromhost_q == '0) && !wr_from;
  assign host_load        = fromhost_valid_i && fromhost_ready_o;

  // Build the response for the accepted request. Bad addresses read 0 with err.
  always_comb begin
    rsp_d = '0;
    if (!(hit_to || hit_from)) rsp_d.err = 1'b1;
    else if (!req_write_i)     rsp_d.rdata = hit_to ? tohost_q : fromhost_q;
  end

  // Request/response FSM with registered response outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_fire) begin
          state_q     <= RESP;
          rsp_valid_o <= 1'b1;
          rsp_rdata_o <= rsp_d.rdata;
          rsp_err_o   <= rsp_d.err;
        end
        RESP: if (rsp_ready_i) begin
          state_q     <= IDLE;
          rsp_valid_o <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_o <= 1'b0;
        end
      endcase
    end
  end

  // tohost register, pend flag and the sticky exit latch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tohost_q      <= '0;
      tohost_pend_q <= 1'b0;
      exit_valid_o  <= 1'b0;
      exit_code_o   <= '0;
    end else if (wr_to) begin
      tohost_q <= to_merged;
      if (to_merged[0]) begin
        // Exit word: only the first one is recorded. It is never forwarded.
        tohost_pend_q <= 1'b0;
        if (!exit_valid_o) begin
          exit_valid_o <= 1'b1;
          exit_code_o  <= to_merged[32:1];
        end
      end else begin
        tohost_pend_q <= (to_merged != '0);
      end
    end else if (pop) begin
      tohost_q      <= '0;
      tohost_pend_q <= 1'b0;
    end
  end

  // fromhost register: the device write (usually an ack of 0) or a host load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        fromhost_q <= '0;
    else if (wr_from)   fromhost_q <= from_merged;
    else if (host_load) fromhost_q <= fromhost_data_i;
  end

endmodule
